// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: widths, FSM state encoding and
// the buffered {pc, instr} entry.
package fetch_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Fetches are halfword granular, so redirect targets drop bit 0.
    function automatic logic [PC_W-1:0] halfword_align(input logic [PC_W-1:0] a);
        return a & ~PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush and a registered head entry.
// head/head_valid always reflect the oldest stored entry, one cycle after it lands.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           wdata,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   head_valid,
    output logic [$clog2(DEPTH):0] level_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
    logic [CNT_W-1:0] count, remain;
    logic             do_push, do_pop;

    always_comb begin
        do_pop      = pop && (count != '0);
        do_push     = push && (count != CNT_W'(DEPTH)) && !flush;
        remain      = count - CNT_W'(do_pop);
        level_next  = flush ? '0 : remain + CNT_W'(do_push);
        rd_ptr_next = flush ? '0 : rd_ptr + PTR_W'(do_pop);
        wr_ptr_next = flush ? '0 : wr_ptr + PTR_W'(do_push);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // A push into a buffer that is empty after this cycle's pop bypasses
    // storage straight into the head register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr_next;
            wr_ptr     <= wr_ptr_next;
            count      <= level_next;
            head_valid <= (level_next != '0);
            if (!flush) begin
                if (remain == '0 && do_push) begin
                    head <= wdata;
                end else if (remain != '0) begin
                    head <= mem[rd_ptr_next];
                end
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, single-outstanding memory request FSM and
// redirect handling, feeding the fetch_fifo instruction buffer.
//   state   | meaning
//   IDLE    | after reset, no request issued
//   REQ     | issuing/holding requests while the buffer has room
//   DISCARD | redirected with a request in flight; wait for its ack and drop it
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               PCSrc,
    input  logic [PC_W-1:0]    branch_target,
    output logic [INSTR_W-1:0] Instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t     state;
    logic [PC_W-1:0]  fetch_pc, pc_next, redirect_pc;
    logic             xfer, push, flush, space_next;
    logic [CNT_W-1:0] level_next;
    fetch_entry_t     wr_entry, head;

    always_comb begin
        redirect_pc    = halfword_align(branch_target);
        xfer           = imem_req && imem_ack;
        flush          = PCSrc && (state != IDLE);
        push           = (state == REQ) && xfer && !PCSrc;
        wr_entry.pc    = imem_addr;
        wr_entry.instr = imem_rdata;
        space_next     = level_next < CNT_W'(FIFO_DEPTH);
        if (PCSrc) begin
            pc_next = redirect_pc;
        end else if (push) begin
            pc_next = fetch_pc + PC_W'(2);
        end else begin
            pc_next = fetch_pc;
        end
    end

    // The request is registered from next-cycle buffer occupancy, so a
    // zero-wait memory still sustains one fetch per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            fetch_pc <= pc_next;
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= space_next;
                    imem_addr <= pc_next;
                end
                REQ: begin
                    if (PCSrc && imem_req && !imem_ack) begin
                        state <= DISCARD;
                    end else begin
                        imem_req  <= space_next;
                        imem_addr <= pc_next;
                    end
                end
                DISCARD: begin
                    if (xfer) begin
                        state     <= REQ;
                        imem_req  <= space_next;
                        imem_addr <= pc_next;
                    end
                end
                default: begin
                    state     <= IDLE;
                    imem_req  <= 1'b0;
                    imem_addr <= RESET_PC;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .wdata     (wr_entry),
        .pop       (instr_ready),
        .head      (head),
        .head_valid(instr_valid),
        .level_next(level_next)
    );

    assign Instr    = head.instr;
    assign instr_pc = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model with programmable ack
// latency, expected {pc, instr} queued at stimulus time and checked on pops.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, PCSrc, instr_valid, instr_ready;
    logic [15:0] imem_addr, imem_rdata, branch_target, Instr, instr_pc;

    logic        w_req, w_ack, w_valid, w_pcsrc, w_ready;
    logic [15:0] w_addr, w_rdata, w_bt, w_instr, w_pc;

    logic        mem_en, ack_force;
    int          mem_lat;
    int          wait_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    fetch_entry_t sb[$];
    fetch_entry_t mon_e;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = ack_force | (mem_en & imem_req & (wait_cnt == mem_lat));
    assign w_ack      = w_req;
    assign w_rdata    = mem_word(w_addr);

    always @(posedge clk) begin
        if (!mem_en || !imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    fetch_unit #(.RESET_PC(16'h0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .PCSrc(PCSrc), .branch_target(branch_target),
        .Instr(Instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    fetch_unit #(.RESET_PC(16'hFFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .PCSrc(w_pcsrc), .branch_target(w_bt),
        .Instr(w_instr), .instr_pc(w_pc),
        .instr_valid(w_valid), .instr_ready(w_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_pc(input logic [15:0] pc);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        chk(tag, 32'(sb.size()), 0);
    endtask

    always @(negedge clk) begin
        if (reset && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(instr_valid), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("pop_pc", 32'(instr_pc), 32'(mon_e.pc));
                chk("pop_instr", 32'(Instr), 32'(mon_e.instr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset = 1'b0; PCSrc = 1'b0; branch_target = '0; instr_ready = 1'b1;
        mem_en = 1'b1; ack_force = 1'b0; mem_lat = 0;
        w_pcsrc = 1'b0; w_bt = '0; w_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", 32'(Instr), 0);
        chk("rst_pc", 32'(instr_pc), 0);
        chk("rst_wrap_addr", 32'(w_addr), 32'hFFFC);
        reset = 1'b1;

        // zero-wait streaming, one instruction per cycle
        for (int i = 0; i < 8; i++) expect_pc(16'(2 * i));
        @(negedge clk);
        chk("t1_req", 32'(imem_req), 1);
        chk("t1_lat_valid", 32'(instr_valid), 0);
        @(negedge clk);
        chk("t1_first_valid", 32'(instr_valid), 1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("t1_stream_valid", 32'(instr_valid), 1);
        end
        @(posedge clk);
        #1 instr_ready = 1'b0;

        // consumer stall: buffer fills, request drops, nothing lost
        for (int i = 0; i < DEPTH; i++) expect_pc(16'(16 + 2 * i));
        repeat (6) @(negedge clk);
        chk("t2_full_req", 32'(imem_req), 0);
        chk("t2_full_valid", 32'(instr_valid), 1);
        chk("t2_full_head", 32'(instr_pc), 16);
        mem_en = 1'b0;
        @(posedge clk);
        #1 instr_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t2_drain_valid", 32'(instr_valid), 0);
        chk("t2_drain_sb", 32'(sb.size()), 0);
        chk("t2_next_req", 32'(imem_req), 1);
        chk("t2_next_addr", 32'(imem_addr), 32'(16 + 2 * DEPTH));

        // redirect while a 3-cycle transfer is pending
        mem_lat = 3; mem_en = 1'b1; instr_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk("t3_req", 32'(imem_req), 1);
        expect_pc(16'h0100);
        expect_pc(16'h0102);
        PCSrc = 1'b1; branch_target = 16'h0101;
        @(posedge clk);
        #1 PCSrc = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_hold_addr", 32'(imem_addr), 0);
            chk("t3_hold_req", 32'(imem_req), 1);
            if (imem_ack) begin seen = 1'b1; break; end
        end
        chk("t3_ack_seen", 32'(seen), 1);
        @(negedge clk);
        chk("t3_new_addr", 32'(imem_addr), 32'h0100);
        chk("t3_new_req", 32'(imem_req), 1);
        chk("t3_dropped", 32'(instr_valid), 0);
        drain("t3_drain");
        mem_en = 1'b0;

        // redirect with ack and pop in the same cycle
        mem_lat = 0; mem_en = 1'b1; instr_ready = 1'b1;
        do_reset();
        expect_pc(16'h0000);
        expect_pc(16'h0040);
        expect_pc(16'h0042);
        @(negedge clk);
        @(negedge clk);
        chk("t4_pre_valid", 32'(instr_valid), 1);
        chk("t4_ack", 32'(imem_ack), 1);
        PCSrc = 1'b1; branch_target = 16'h0040;
        @(posedge clk);
        #1 PCSrc = 1'b0;
        @(negedge clk);
        chk("t4_flush_valid", 32'(instr_valid), 0);
        chk("t4_addr", 32'(imem_addr), 32'h0040);
        drain("t4_drain");
        instr_ready = 1'b0; mem_en = 1'b0;

        // PC wrap from RESET_PC=FFFC
        do_reset();
        @(negedge clk);
        chk("t5_lat_valid", 32'(w_valid), 0);
        @(negedge clk);
        chk("t5_valid0", 32'(w_valid), 1);
        chk("t5_pc0", 32'(w_pc), 32'hFFFC);
        chk("t5_instr0", 32'(w_instr), 32'(mem_word(16'hFFFC)));
        @(negedge clk);
        chk("t5_valid1", 32'(w_valid), 1);
        chk("t5_pc1", 32'(w_pc), 32'hFFFE);
        @(negedge clk);
        chk("t5_valid2", 32'(w_valid), 1);
        chk("t5_pc2", 32'(w_pc), 32'h0000);

        // reset mid-wait, stale ack in IDLE after release
        mem_lat = 3; mem_en = 1'b1; instr_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk("t6_req", 32'(imem_req), 1);
        @(negedge clk);
        reset = 1'b0; mem_en = 1'b0;
        #1;
        chk("t6_rst_req", 32'(imem_req), 0);
        @(negedge clk);
        reset = 1'b1; ack_force = 1'b1;
        @(posedge clk);
        #1 ack_force = 1'b0;
        @(negedge clk);
        chk("t6_valid", 32'(instr_valid), 0);
        chk("t6_req_after", 32'(imem_req), 1);
        chk("t6_addr_after", 32'(imem_addr), 0);
        @(negedge clk);
        chk("t6_valid_late", 32'(instr_valid), 0);
        chk("final_sb", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
